dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Word-organised data memory with a byte/half/word load-store front end.
// A zero-fill sweep runs after reset before requests are accepted.
module dmem_lsu #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        fsm_state
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-3:0] CLR_LAST = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-3:0] clr_cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] idx;
    logic              accept;
    logic              req_err;
    logic [31:0]       word;
    logic [7:0]        lb;
    logic [15:0]       lh;
    logic [31:0]       load_data;
    logic [3:0]        wmask;
    logic [31:0]       wlanes;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high and rst is low; the response is a one-cycle
    // rsp_valid pulse in the following cycle and can never be stalled.
    assign accept    = req_valid & req_ready & ~rst;
    assign idx       = req_addr[ADDR_W-1:2];
    assign word      = mem[idx];
    assign fsm_state = state;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11) req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ((req_addr >> ADDR_W) != 32'd0) req_err = 1'b1;
    end

    always_comb begin
        lb = word[7:0];
        case (req_addr[1:0])
            2'd0:    lb = word[7:0];
            2'd1:    lb = word[15:8];
            2'd2:    lb = word[23:16];
            default: lb = word[31:24];
        endcase
        lh = req_addr[1] ? word[31:16] : word[15:0];
        case (req_size)
            2'b00:   load_data = req_unsigned ? {24'd0, lb} : {{24{lb[7]}}, lb};
            2'b01:   load_data = req_unsigned ? {16'd0, lh} : {{16{lh[15]}}, lh};
            default: load_data = word;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks placement.
    always_comb begin
        wmask  = 4'b0000;
        wlanes = req_wdata;
        case (req_size)
            2'b00: begin
                wlanes = {4{req_wdata[7:0]}};
                wmask  = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wlanes = {2{req_wdata[15:0]}};
                wmask  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    // Memory array carries no reset so contents survive when the sweep is off.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_we && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt   <= '0;
            busy      <= CLEAR_ON_RESET;
            req_ready <= !CLEAR_ON_RESET;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & req_err;
            rsp_rdata <= (accept && !req_we && !req_err) ? load_data : 32'd0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state     <= RUN;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
